pipemem_stage: RTL

Memory-stage datapath block of the five-stage pipelined CPU. It sits directly downstream of the EX/MEM pipeline register and consumes that register's `mwmem`, `malu` and `mb` outputs. It holds the word-addressed data RAM and a small memory-mapped I/O window (three output port registers, two synchronised input ports). It returns the load word `mmo` to the MEM/WB register.

---
 rtl/pipemem_stage.sv | 55 +++++
 1 files changed

// File: rtl/pipemem_stage.sv
// pipemem_stage: MEM-stage data RAM plus memory-mapped output ports and
// two-flop synchronised input ports, decoded from malu[7:0].
module pipemem_stage #(
  parameter int DEPTH = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] mmo,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] mem [DEPTH];
  logic [31:0] s1_0, s1_1, s2_0, s2_1;
  logic [7:0] a;
  logic [AW-1:0] idx;
  logic unused_hi;
  assign a = malu[7:0];
  assign idx = malu[2 +: AW];
  assign unused_hi = ^malu[31:8];
  // RAM has no reset; the resetn term only blocks stores while reset is held
  always_ff @(posedge clock)
    if (resetn && mwmem && !a[7]) mem[idx] <= mb;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      s1_0 <= '0;
      s1_1 <= '0;
      s2_0 <= '0;
      s2_1 <= '0;
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else begin
      s1_0 <= in_port0;
      s1_1 <= in_port1;
      s2_0 <= s1_0;
      s2_1 <= s1_1;
      if (mwmem && a == 8'h80) out_port0 <= mb;
      if (mwmem && a == 8'h84) out_port1 <= mb;
      if (mwmem && a == 8'h88) out_port2 <= mb;
    end
  always_comb
    mmo = !a[7]       ? mem[idx]  :
          a == 8'h80  ? out_port0 :
          a == 8'h84  ? out_port1 :
          a == 8'h88  ? out_port2 :
          a == 8'hC0  ? s2_0      :
          a == 8'hC4  ? s2_1      : '0;
endmodule
